// File: rtl/xbar_arb2_if.sv
// Request/response bus between a master and the arbiter, or between the arbiter and the slave.
// The master drives the request fields. The slave drives ack, resp and rdata.
interface xbar_arb2_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [BW-1:0] be;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          resp;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, resp, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/xbar_arb2.sv
// Two-master to one-slave arbiter. It supports round-robin or fixed master-1 priority.
// If the slave does not answer a read, a response is synthesized after a timeout.
module xbar_arb2 #(
  parameter string       ARB_MODE     = "RR",
  parameter int unsigned RESP_TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       arst_i,
  xbar_arb2_if.slave  m0,
  xbar_arb2_if.slave  m1,
  xbar_arb2_if.master s,
  output logic       timeout_o
);

  localparam int unsigned CW       = 16;
  localparam int unsigned DW       = 32;
  localparam logic [CW-1:0] CNT_LAST = CW'(RESP_TIMEOUT - 1);
  localparam bit          FIXED_M1 = (ARB_MODE == "M1");

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          winner;
  logic          s_req_c;
  logic          ack_hit;
  logic          resp_hit;
  logic [DW-1:0] rdata_c;

  logic          g_we;
  logic [31:0]   g_addr;
  logic [3:0]    g_be;
  logic [31:0]   g_wdata;

  // Request fields of the master that currently holds the grant
  assign g_we    = grant_q ? m1.we    : m0.we;
  assign g_addr  = grant_q ? m1.addr  : m0.addr;
  assign g_be    = grant_q ? m1.be    : m0.be;
  assign g_wdata = grant_q ? m1.wdata : m0.wdata;

  // When both masters request in round-robin mode, the master that was not served last wins
  always_comb begin
    if (FIXED_M1)
      winner = m1.req;
    else if (m0.req && m1.req)
      winner = ~last_q;
    else
      winner = m1.req;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    s_req_c   = 1'b0;
    ack_hit   = 1'b0;
    resp_hit  = 1'b0;
    rdata_c   = '0;
    timeout_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          grant_d = winner;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        s_req_c = 1'b1;
        ack_hit = s.ack;
        if (s.ack) begin
          if (g_we) begin
            state_d = IDLE;
            last_d  = grant_q;
          end else begin
            state_d = RESP;
            cnt_d   = '0;
          end
        end
      end
      RESP: begin
        // A real response that arrives on the last allowed cycle takes precedence over the timeout
        if (s.resp) begin
          resp_hit = 1'b1;
          rdata_c  = s.rdata;
          last_d   = grant_q;
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          resp_hit  = 1'b1;
          timeout_o = 1'b1;
          last_d    = grant_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s.req   = s_req_c;
  assign s.we    = s_req_c & g_we;
  assign s.addr  = s_req_c ? g_addr  : '0;
  assign s.be    = s_req_c ? g_be    : '0;
  assign s.wdata = s_req_c ? g_wdata : '0;

  // Slave handshakes are routed only to the granted master
  assign m0.ack   = ack_hit & ~grant_q;
  assign m1.ack   = ack_hit & grant_q;
  assign m0.resp  = resp_hit & ~grant_q;
  assign m1.resp  = resp_hit & grant_q;
  assign m0.rdata = grant_q ? '0 : rdata_c;
  assign m1.rdata = grant_q ? rdata_c : '0;

endmodule

// File: tb/tb_xbar_arb2.sv
// Directed bench for xbar_arb2.
// It covers round-robin with a short response timeout, and a second instance in fixed master-1 mode.
module tb_xbar_arb2;

  logic clk;
  logic rst;
  logic timeout_rr;
  logic timeout_m1;
  int   errors;
  int   checks;

  xbar_arb2_if m0_if ();
  xbar_arb2_if m1_if ();
  xbar_arb2_if s_if ();
  xbar_arb2_if m0b_if ();
  xbar_arb2_if m1b_if ();
  xbar_arb2_if sb_if ();

  xbar_arb2 #(.ARB_MODE("RR"), .RESP_TIMEOUT(8)) dut_rr (
    .clk_i(clk), .arst_i(rst), .m0(m0_if), .m1(m1_if), .s(s_if), .timeout_o(timeout_rr)
  );

  xbar_arb2 #(.ARB_MODE("M1"), .RESP_TIMEOUT(1024)) dut_m1 (
    .clk_i(clk), .arst_i(rst), .m0(m0b_if), .m1(m1b_if), .s(sb_if), .timeout_o(timeout_m1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce;
    m0_if.req = 0; m0_if.we = 0; m0_if.addr = 0; m0_if.be = 0; m0_if.wdata = 0;
    m1_if.req = 0; m1_if.we = 0; m1_if.addr = 0; m1_if.be = 0; m1_if.wdata = 0;
    s_if.ack = 0; s_if.resp = 0; s_if.rdata = 0;
    m0b_if.req = 0; m0b_if.we = 0; m0b_if.addr = 0; m0b_if.be = 0; m0b_if.wdata = 0;
    m1b_if.req = 0; m1b_if.we = 0; m1b_if.addr = 0; m1b_if.be = 0; m1b_if.wdata = 0;
    sb_if.ack = 0; sb_if.resp = 0; sb_if.rdata = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    quiesce();
    m0_if.req = 1; m0_if.addr = 32'h1234; m0_if.wdata = 32'h5555;
    m1_if.req = 1; s_if.ack = 1; s_if.resp = 1; s_if.rdata = 32'hffffffff;
    m0b_if.req = 1; m1b_if.req = 1; sb_if.ack = 1; sb_if.resp = 1; sb_if.rdata = 32'hffffffff;
    tick(); tick(); #1;
    checks++;
    if ({s_if.req, m0_if.ack, m1_if.ack, m0_if.resp, m1_if.resp, timeout_rr} !== 6'b0) begin
      errors++;
      $display("FAIL rst_ctrl: got %b expected 000000",
               {s_if.req, m0_if.ack, m1_if.ack, m0_if.resp, m1_if.resp, timeout_rr});
    end
    checks++;
    if ({s_if.addr, s_if.wdata, s_if.be, s_if.we} !== 69'h0) begin
      errors++;
      $display("FAIL rst_fields: got %h expected 0", {s_if.addr, s_if.wdata, s_if.be, s_if.we});
    end
    checks++;
    if ({m0_if.rdata, m1_if.rdata} !== 64'h0) begin
      errors++;
      $display("FAIL rst_rdata: got %h expected 0", {m0_if.rdata, m1_if.rdata});
    end
    checks++;
    if ({sb_if.req, m0b_if.ack, m1b_if.ack, m0b_if.resp, m1b_if.resp, timeout_m1} !== 6'b0) begin
      errors++;
      $display("FAIL rst_m1_ctrl: got %b expected 000000",
               {sb_if.req, m0b_if.ack, m1b_if.ack, m0b_if.resp, m1b_if.resp, timeout_m1});
    end
    quiesce();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_m0;
    m0_if.req = 1; m0_if.we = 1; m0_if.addr = 32'h0; m0_if.wdata = 32'hdeadbeef; m0_if.be = 4'hf;
    #1;
    checks++;
    if (s_if.req !== 1'b0) begin
      errors++; $display("FAIL wr_idle_sreq: got %b expected 0", s_if.req);
    end
    tick(); #1;
    checks++;
    if ({s_if.req, s_if.we, s_if.addr, s_if.be, s_if.wdata} !== {1'b1, 1'b1, 32'h0, 4'hf, 32'hdeadbeef}) begin
      errors++;
      $display("FAIL wr_fields: got %h expected %h", {s_if.req, s_if.we, s_if.addr, s_if.be, s_if.wdata},
               {1'b1, 1'b1, 32'h0, 4'hf, 32'hdeadbeef});
    end
    checks++;
    if ({m0_if.ack, m1_if.ack} !== 2'b00) begin
      errors++; $display("FAIL wr_wait_ack: got %b expected 00", {m0_if.ack, m1_if.ack});
    end
    tick();
    s_if.ack = 1; #1;
    checks++;
    if ({m0_if.ack, m1_if.ack, m0_if.resp, m1_if.resp} !== 4'b1000) begin
      errors++;
      $display("FAIL wr_ack: got %b expected 1000", {m0_if.ack, m1_if.ack, m0_if.resp, m1_if.resp});
    end
    tick();
    s_if.ack = 0; m0_if.req = 0; m0_if.we = 0; #1;
    checks++;
    if ({s_if.req, m0_if.ack, m1_if.ack} !== 3'b000) begin
      errors++; $display("FAIL wr_done: got %b expected 000", {s_if.req, m0_if.ack, m1_if.ack});
    end
  endtask

  task automatic test_read_m1;
    m1_if.req = 1; m1_if.we = 0; m1_if.addr = 32'h0; m1_if.be = 4'hf;
    #1;
    tick();
    s_if.ack = 1; #1;
    checks++;
    if ({m1_if.ack, m0_if.ack, s_if.req, s_if.we} !== 4'b1010) begin
      errors++; $display("FAIL rd_ack: got %b expected 1010", {m1_if.ack, m0_if.ack, s_if.req, s_if.we});
    end
    tick();
    m1_if.req = 0; s_if.ack = 0; #1;
    checks++;
    if ({s_if.req, m1_if.resp, m1_if.rdata} !== 34'h0) begin
      errors++; $display("FAIL rd_wait0: got %h expected 0", {s_if.req, m1_if.resp, m1_if.rdata});
    end
    tick(); #1;
    checks++;
    if ({m1_if.resp, timeout_rr} !== 2'b00) begin
      errors++; $display("FAIL rd_wait1: got %b expected 00", {m1_if.resp, timeout_rr});
    end
    tick();
    s_if.resp = 1; s_if.rdata = 32'hdeadbeef; #1;
    checks++;
    if ({m1_if.resp, m1_if.rdata} !== {1'b1, 32'hdeadbeef}) begin
      errors++; $display("FAIL rd_resp: got %h expected %h", {m1_if.resp, m1_if.rdata}, {1'b1, 32'hdeadbeef});
    end
    checks++;
    if ({m0_if.resp, m0_if.rdata, m0_if.ack, timeout_rr} !== 35'h0) begin
      errors++;
      $display("FAIL rd_other: got %h expected 0", {m0_if.resp, m0_if.rdata, m0_if.ack, timeout_rr});
    end
    tick();
    s_if.resp = 0; #1;
    checks++;
    if ({m1_if.resp, m1_if.rdata} !== 33'h0) begin
      errors++; $display("FAIL rd_done: got %h expected 0", {m1_if.resp, m1_if.rdata});
    end
    s_if.resp = 1; #1;
    checks++;
    if ({m0_if.resp, m1_if.resp, m0_if.rdata, m1_if.rdata} !== 66'h0) begin
      errors++;
      $display("FAIL stray_resp: got %h expected 0", {m0_if.resp, m1_if.resp, m0_if.rdata, m1_if.rdata});
    end
    s_if.resp = 0;
  endtask

  task automatic test_round_robin;
    logic        exp;
    logic [31:0] rd;
    m0_if.req = 1; m0_if.we = 0; m0_if.addr = 32'h100;
    m1_if.req = 1; m1_if.we = 0; m1_if.addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2) == 1;
      rd  = 32'h1000 + 32'(i);
      #1;
      checks++;
      if (s_if.req !== 1'b0) begin
        errors++; $display("FAIL rr_idle[%0d]: got %b expected 0", i, s_if.req);
      end
      tick();
      s_if.ack = 1; #1;
      checks++;
      if ({m1_if.ack, m0_if.ack, s_if.addr} !== {exp, ~exp, (exp ? 32'h200 : 32'h100)}) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %h expected %h", i, {m1_if.ack, m0_if.ack, s_if.addr},
                 {exp, ~exp, (exp ? 32'h200 : 32'h100)});
      end
      tick();
      s_if.ack = 0; s_if.resp = 1; s_if.rdata = rd; #1;
      checks++;
      if ({m1_if.resp, m0_if.resp, m0_if.rdata, m1_if.rdata} !==
          {exp, ~exp, (exp ? 32'h0 : rd), (exp ? rd : 32'h0)}) begin
        errors++;
        $display("FAIL rr_resp[%0d]: got %h expected %h", i, {m1_if.resp, m0_if.resp, m0_if.rdata, m1_if.rdata},
                 {exp, ~exp, (exp ? 32'h0 : rd), (exp ? rd : 32'h0)});
      end
      tick();
      s_if.resp = 0;
    end
    m0_if.req = 0; m1_if.req = 0;
  endtask

  task automatic test_timeout;
    m0_if.req = 1; m0_if.we = 0; m0_if.addr = 32'h40;
    #1;
    tick();
    s_if.ack = 1; #1;
    tick();
    s_if.ack = 0; m0_if.req = 0;
    m1_if.req = 1; m1_if.we = 1; m1_if.addr = 32'h80; m1_if.wdata = 32'h12345678; m1_if.be = 4'h3;
    for (int k = 0; k < 7; k++) begin
      if (k == 2) begin
        s_if.ack = 1; #1;
        checks++;
        if ({m0_if.ack, m1_if.ack} !== 2'b00) begin
          errors++; $display("FAIL stray_ack: got %b expected 00", {m0_if.ack, m1_if.ack});
        end
        s_if.ack = 0;
      end
      #1;
      checks++;
      if ({m0_if.resp, timeout_rr, m1_if.ack, s_if.req} !== 4'b0000) begin
        errors++;
        $display("FAIL to_wait[%0d]: got %b expected 0000", k, {m0_if.resp, timeout_rr, m1_if.ack, s_if.req});
      end
      tick();
    end
    #1;
    checks++;
    if ({m0_if.resp, m0_if.rdata, timeout_rr, m1_if.resp} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL to_fire: got %h expected %h", {m0_if.resp, m0_if.rdata, timeout_rr, m1_if.resp},
               {1'b1, 32'h0, 1'b1, 1'b0});
    end
    tick(); #1;
    checks++;
    if ({timeout_rr, m0_if.resp, s_if.req} !== 3'b000) begin
      errors++; $display("FAIL to_idle: got %b expected 000", {timeout_rr, m0_if.resp, s_if.req});
    end
    tick();
    s_if.ack = 1; #1;
    checks++;
    if ({s_if.req, s_if.we, s_if.addr, m1_if.ack, m0_if.ack} !== {1'b1, 1'b1, 32'h80, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL to_next: got %h expected %h", {s_if.req, s_if.we, s_if.addr, m1_if.ack, m0_if.ack},
               {1'b1, 1'b1, 32'h80, 1'b1, 1'b0});
    end
    tick();
    s_if.ack = 0; m1_if.req = 0; m1_if.we = 0;
  endtask

  task automatic test_timeout_race;
    m0_if.req = 1; m0_if.we = 0; m0_if.addr = 32'h44;
    #1;
    tick();
    s_if.ack = 1; #1;
    tick();
    s_if.ack = 0; m0_if.req = 0;
    repeat (7) tick();
    s_if.resp = 1; s_if.rdata = 32'h5a5a5a5a; #1;
    checks++;
    if ({m0_if.resp, m0_if.rdata, timeout_rr} !== {1'b1, 32'h5a5a5a5a, 1'b0}) begin
      errors++;
      $display("FAIL race: got %h expected %h", {m0_if.resp, m0_if.rdata, timeout_rr},
               {1'b1, 32'h5a5a5a5a, 1'b0});
    end
    tick();
    s_if.resp = 0;
  endtask

  task automatic test_reset_mid_resp;
    m1_if.req = 1; m1_if.we = 0; m1_if.addr = 32'h0;
    #1;
    tick();
    s_if.ack = 1; #1;
    tick();
    s_if.ack = 0; m1_if.req = 0;
    tick();
    rst = 1'b1; #1;
    tick();
    rst = 1'b0;
    s_if.resp = 1; s_if.rdata = 32'hcafef00d; #1;
    checks++;
    if ({m0_if.resp, m1_if.resp, m1_if.rdata, timeout_rr} !== 35'h0) begin
      errors++;
      $display("FAIL rst_late_resp: got %h expected 0", {m0_if.resp, m1_if.resp, m1_if.rdata, timeout_rr});
    end
    tick();
    s_if.resp = 0;
    m0_if.req = 1; m0_if.we = 0; m0_if.addr = 32'h10;
    m1_if.req = 1; m1_if.we = 0; m1_if.addr = 32'h20;
    #1;
    checks++;
    if (s_if.req !== 1'b0) begin
      errors++; $display("FAIL rst_idle: got %b expected 0", s_if.req);
    end
    tick();
    s_if.ack = 1; #1;
    checks++;
    if ({m0_if.ack, m1_if.ack, s_if.addr} !== {1'b1, 1'b0, 32'h10}) begin
      errors++;
      $display("FAIL rst_tie: got %h expected %h", {m0_if.ack, m1_if.ack, s_if.addr}, {1'b1, 1'b0, 32'h10});
    end
    tick();
    s_if.ack = 0; m0_if.req = 0; m1_if.req = 0;
    s_if.resp = 1; s_if.rdata = 32'h1; #1;
    checks++;
    if ({m0_if.resp, m1_if.resp, m0_if.rdata} !== {1'b1, 1'b0, 32'h1}) begin
      errors++;
      $display("FAIL rst_tie_resp: got %h expected %h", {m0_if.resp, m1_if.resp, m0_if.rdata}, {1'b1, 1'b0, 32'h1});
    end
    tick();
    s_if.resp = 0;
  endtask

  task automatic test_fixed_m1;
    logic [31:0] rd;
    m0b_if.req = 1; m0b_if.we = 0; m0b_if.addr = 32'h300;
    m1b_if.req = 1; m1b_if.we = 0; m1b_if.addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      rd = 32'h2000 + 32'(i);
      #1;
      tick();
      sb_if.ack = 1; #1;
      checks++;
      if ({m1b_if.ack, m0b_if.ack, sb_if.addr} !== {1'b1, 1'b0, 32'h400}) begin
        errors++;
        $display("FAIL m1_grant[%0d]: got %h expected %h", i, {m1b_if.ack, m0b_if.ack, sb_if.addr},
                 {1'b1, 1'b0, 32'h400});
      end
      tick();
      sb_if.ack = 0; sb_if.resp = 1; sb_if.rdata = rd; #1;
      checks++;
      if ({m1b_if.resp, m1b_if.rdata, m0b_if.resp} !== {1'b1, rd, 1'b0}) begin
        errors++;
        $display("FAIL m1_resp[%0d]: got %h expected %h", i, {m1b_if.resp, m1b_if.rdata, m0b_if.resp},
                 {1'b1, rd, 1'b0});
      end
      tick();
      sb_if.resp = 0;
    end
    m1b_if.req = 0;
    #1;
    tick();
    sb_if.ack = 1; #1;
    checks++;
    if ({m0b_if.ack, m1b_if.ack, sb_if.addr} !== {1'b1, 1'b0, 32'h300}) begin
      errors++;
      $display("FAIL m1_solo_m0: got %h expected %h", {m0b_if.ack, m1b_if.ack, sb_if.addr}, {1'b1, 1'b0, 32'h300});
    end
    tick();
    sb_if.ack = 0; m0b_if.req = 0; sb_if.resp = 1; sb_if.rdata = 32'h77; #1;
    checks++;
    if ({m0b_if.resp, m0b_if.rdata, timeout_m1} !== {1'b1, 32'h77, 1'b0}) begin
      errors++;
      $display("FAIL m1_solo_resp: got %h expected %h", {m0b_if.resp, m0b_if.rdata, timeout_m1},
               {1'b1, 32'h77, 1'b0});
    end
    tick();
    sb_if.resp = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_m0();
    test_read_m1();
    test_round_robin();
    test_timeout();
    test_timeout_race();
    test_reset_mid_resp();
    test_fixed_m1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
